// File: rtl/calc_pkg.sv
// Shared constants for the add/subtract datapath: op encoding and default geometry.
package calc_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CHUNK = 2;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module addsub_chunk
  import calc_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    w_c[0] = c_in;
    s      = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = w_c[CHUNK];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor resolving CHUNK bits per stage with valid/ready flow control.
// Optional signed saturation of the result when ADDSUB_SAT_EN is defined.
module addsub_pipe
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;

  if (CHUNK == 0 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH (%0d) must be >= 2 and a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic w_en;
  logic w_sub;

  assign w_sub    = (op_e'(op_sub) == OP_SUB);
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Each stage carries only the operand bits not yet resolved and the low sum bits already done.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * CHUNK;
    localparam int unsigned LOW = (k + 1) * CHUNK;

    logic [REM-1:0]   w_a;
    logic [REM-1:0]   w_b;
    logic             w_cin;
    logic             w_vin;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic [LOW-1:0]   w_cat;
    logic [LOW-1:0]   w_next;

    logic             r_v;
    logic             r_c;
    logic [LOW-1:0]   r_s;

    if (k == 0) begin : g_head
      assign w_a   = a;
      assign w_b   = b ^ {WIDTH{w_sub}};
      assign w_cin = w_sub;
      assign w_vin = in_valid;
      assign w_cat = w_s;
    end else begin : g_link
      assign w_a   = g_stage[k-1].g_fwd.r_a_hi;
      assign w_b   = g_stage[k-1].g_fwd.r_b_hi;
      assign w_cin = g_stage[k-1].r_c;
      assign w_vin = g_stage[k-1].r_v;
      assign w_cat = {w_s, g_stage[k-1].r_s};
    end

    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a    (w_a[CHUNK-1:0]),
      .b    (w_b[CHUNK-1:0]),
      .c_in (w_cin),
      .s    (w_s),
      .c_out(w_cout)
    );

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] r_a_hi;
      logic [REM-CHUNK-1:0] r_b_hi;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_en) begin
          r_a_hi <= w_a[REM-1:CHUNK];
          r_b_hi <= w_b[REM-1:CHUNK];
        end
      end

      assign w_next = w_cat;
    end else begin : g_last
      logic w_ov;
      logic r_ov;

      // w_b is already the effective (inverted for subtract) operand.
      assign w_ov = (w_a[CHUNK-1] == w_b[CHUNK-1]) && (w_s[CHUNK-1] != w_a[CHUNK-1]);

`ifdef ADDSUB_SAT_EN
      always_comb begin
        w_next = w_cat;
        if (w_ov) begin
          w_next = w_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign w_next = w_cat;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ov <= 1'b0;
        end else if (w_en) begin
          r_ov <= w_ov;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_vin;
        r_c <= w_cout;
        r_s <= w_next;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_s;
  assign carry_out = g_stage[STAGES-1].r_c;
  assign overflow  = g_stage[STAGES-1].g_last.r_ov;

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; SHALL be a multiple of CHUNK and >= 2.
REQ-002 Parameter CHUNK, default 2: bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operand beat offered.
REQ-006 in_ready  out  1  block accepts the beat this cycle.
REQ-007 a, b  in  WIDTH  operands, two's complement or unsigned.
REQ-008 op_sub  in  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  out  1  result beat held.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 sum  out  WIDTH  result.
REQ-012 carry_out  out  1  MSB carry; for subtract, 1 = no borrow.
REQ-013 overflow  out  1  signed overflow of the true result.

Function
REQ-014 Subtract SHALL be a + ~b + 1: b inverted, carry-in 1; add uses carry-in 0.
REQ-015 Stage k SHALL resolve bits [k*CHUNK +: CHUNK] from the stage k-1 carry; upper operand bits and op_sub travel with the beat.
REQ-016 Pipeline enable en = !out_valid || out_ready; all stage registers, including valid bits, advance only when en = 1.
REQ-017 in_ready SHALL equal en, combinationally.
REQ-018 Beat accepted when in_valid && in_ready; result appears on out_valid exactly STAGES cycles later if en stays 1.
REQ-019 Throughput one beat per cycle with out_ready held high; bubbles (in_valid = 0) propagate as invalid slots.
REQ-020 With out_valid && !out_ready, sum/carry_out/overflow SHALL hold stable; no beat lost, duplicated or reordered.
REQ-021 overflow = (sign a == sign of effective b) && (sign sum != sign a), computed before any saturation.
REQ-022 carry_out SHALL be the carry from bit WIDTH-1 of the final stage.
REQ-023 Results are computed for invalid slots too, but out_valid gates them; the consumer ignores sum while out_valid = 0.

Reset
REQ-024 rst_n low SHALL clear all stage valid bits, out_valid, sum, carry_out and overflow to 0 immediately, regardless of clk.
REQ-025 In-flight beats at reset SHALL be discarded; none appear after release.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n goes high.

Configuration
REQ-027 Macro ADDSUB_SAT_EN defined: when overflow = 1, sum saturates to the signed max (0x7F.. for a positive overflow) or the signed min (0x80.. for a negative overflow); carry_out is unchanged.
REQ-028 ADDSUB_SAT_EN undefined: sum SHALL wrap modulo 2^WIDTH; no saturation logic is synthesised.

Structure
REQ-029 Shared package calc_pkg SHALL hold the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the default WIDTH/CHUNK constants.
REQ-030 One sub-module, addsub_chunk, SHALL be a combinational CHUNK-bit ripple adder (a, b, c_in -> s, c_out), instantiated once per stage.
REQ-031 Parameter legality (WIDTH % CHUNK == 0) SHALL be checked at elaboration.

Verification (WIDTH = 8, CHUNK = 2, latency 4)
REQ-032 add 0x7F + 0x01 -> sum 0x80, carry_out 0, overflow 1; with ADDSUB_SAT_EN, sum 0x7F.
REQ-033 sub 0x05 - 0x07 -> sum 0xFE, carry_out 0, overflow 0; add 0xFF + 0x01 -> sum 0x00, carry_out 1, overflow 0.
REQ-034 sub 0x80 - 0x01 -> sum 0x7F, overflow 1, carry_out 1; with ADDSUB_SAT_EN, sum 0x80.
REQ-035 Six back-to-back beats, out_ready low for 3 cycles after the first result -> in_ready low for those 3 cycles, outputs held, all six results in order.
REQ-036 rst_n pulsed low with 3 beats in flight -> out_valid 0 at once and no result emerges within 8 cycles after release; in_ready 1 on the first cycle.
